// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, hazard stall/flush,
// NOP injection on bubbles and a one-entry skid buffer so fetch can keep
// streaming while decode applies back-pressure.
//
// Handshake: a beat moves across an interface only on a cycle where both
// valid and ready are high at the rising clock edge. Upstream: inValid/inReady.
// Downstream: outValid/(outReady & ~stall). A producer holding valid must keep
// its payload stable until the beat is taken. inReady is driven straight from
// a register (NOT skidValid), so it has no combinational path from outReady,
// stall or flush.
module if_id_stage #(
    parameter int               XLEN = 32,
    parameter int               ILEN = 32,
    parameter logic [ILEN-1:0]  NOP  = 'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pcAdd4,
    input  logic [ILEN-1:0] inst,
    input  logic            stall,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] pcOut,
    output logic [XLEN-1:0] pcAdd4Out,
    output logic [ILEN-1:0] instOut
);

    // Main slot: drives the outputs directly.
    logic            r_out_valid;
    logic [XLEN-1:0] r_pc_out;
    logic [XLEN-1:0] r_pc4_out;
    logic [ILEN-1:0] r_inst_out;

    // Skid slot: catches the one beat accepted while the main slot is held.
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_pc4;
    logic [ILEN-1:0] r_skid_inst;

    logic w_in_fire;
    logic w_out_fire;
    logic w_main_free;

    // Handshake qualifiers; the stall from the hazard unit gates downstream ready.
    always_comb begin
        w_in_fire   = inValid & ~r_skid_valid;
        w_out_fire  = r_out_valid & outReady & ~stall;
        w_main_free = ~r_out_valid | w_out_fire;
    end

    // Slot update: flush kills everything, otherwise refill main from skid
    // first (keeps FIFO order), then from the input; a held main parks the
    // incoming beat in the skid slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_pc_out     <= '0;
            r_pc4_out    <= '0;
            r_inst_out   <= NOP;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_pc4   <= '0;
            r_skid_inst  <= '0;
        end else if (flush) begin
            // PC fields intentionally hold; only the instruction becomes a NOP.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_inst_out   <= NOP;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_pc_out     <= r_skid_pc;
                r_pc4_out    <= r_skid_pc4;
                r_inst_out   <= r_skid_inst;
                r_skid_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_skid_pc   <= pc;
                    r_skid_pc4  <= pcAdd4;
                    r_skid_inst <= inst;
                end
            end else if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_pc_out    <= pc;
                r_pc4_out   <= pcAdd4;
                r_inst_out  <= inst;
            end else begin
                // Bubble: inject a NOP, keep the last PC for debug visibility.
                r_out_valid <= 1'b0;
                r_inst_out  <= NOP;
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= pc;
            r_skid_pc4   <= pcAdd4;
            r_skid_inst  <= inst;
        end
    end

    // Output drive straight from registers.
    always_comb begin
        inReady   = ~r_skid_valid;
        outValid  = r_out_valid;
        pcOut     = r_pc_out;
        pcAdd4Out = r_pc4_out;
        instOut   = r_inst_out;
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: vector table for streaming, stall/skid,
// flush and bubble behaviour, plus hand-written reset sequences.
module tb_if_id_stage;

    localparam logic [31:0] NOP_I = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] pc;
    logic [31:0] pcAdd4;
    logic [31:0] inst;
    logic        stall;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] pcOut;
    logic [31:0] pcAdd4Out;
    logic [31:0] instOut;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
        logic        e_nop;
    } vec_t;

    vec_t vecs[$];

    if_id_stage dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .pc        (pc),
        .pcAdd4    (pcAdd4),
        .inst      (inst),
        .stall     (stall),
        .flush     (flush),
        .outValid  (outValid),
        .outReady  (outReady),
        .pcOut     (pcOut),
        .pcAdd4Out (pcAdd4Out),
        .instOut   (instOut)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction tagged with its PC: addi x1,x0,pc[11:0]
    function automatic logic [31:0] inst_of(input logic [31:0] p);
        logic [31:0] r;
        r = {p[11:0], 20'h00093};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] p, input logic st,
                         input logic fl, input logic ordy);
        inValid  = iv;
        pc       = p;
        pcAdd4   = p + 32'd4;
        inst     = inst_of(p);
        stall    = st;
        flush    = fl;
        outReady = ordy;
    endtask

    task automatic add(input logic iv, input logic [31:0] p, input logic st,
                       input logic fl, input logic ordy, input logic e_ov,
                       input logic e_ir, input logic [31:0] e_pc, input logic e_nop);
        vec_t v;
        v.iv = iv; v.pc = p; v.st = st; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_nop = e_nop;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_ov, input logic e_ir,
                                 input logic [31:0] e_pc, input logic [31:0] e_pc4,
                                 input logic [31:0] e_inst);
        check({tag, " outValid"},  {31'd0, outValid}, {31'd0, e_ov});
        check({tag, " inReady"},   {31'd0, inReady},  {31'd0, e_ir});
        check({tag, " pcOut"},     pcOut,     e_pc);
        check({tag, " pcAdd4Out"}, pcAdd4Out, e_pc4);
        check({tag, " instOut"},   instOut,   e_inst);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Streaming: 8 back-to-back beats, each visible one cycle later
        for (int i = 0; i < 8; i++)
            add(1, 32'(i * 4), 0, 0, 1, 1, 1, 32'(i * 4), 0);
        // Stall/skid: 0x20 in main, 0x24 parked in skid, 0x28 refused until drained
        add(1, 32'h20, 0, 0, 1, 1, 1, 32'h20, 0);
        add(1, 32'h24, 1, 0, 1, 1, 0, 32'h20, 0);
        add(1, 32'h28, 1, 0, 1, 1, 0, 32'h20, 0);
        add(1, 32'h28, 0, 0, 1, 1, 1, 32'h24, 0);
        add(1, 32'h28, 0, 0, 1, 1, 1, 32'h28, 0);
        add(1, 32'h2C, 0, 0, 1, 1, 1, 32'h2C, 0);
        // Flush with both slots full, 0x48 offered
        add(1, 32'h40, 0, 0, 1, 1, 1, 32'h40, 0);
        add(1, 32'h44, 0, 0, 0, 1, 0, 32'h40, 0);
        add(1, 32'h48, 0, 1, 0, 0, 1, 32'h40, 1);
        // Flush + stall + accepted input: flush wins, beat dropped
        add(1, 32'h4C, 0, 0, 1, 1, 1, 32'h4C, 0);
        add(1, 32'h60, 1, 1, 1, 0, 1, 32'h4C, 1);
        // Bubble after 0x50, then resume; empty main accepts even under stall
        add(1, 32'h50, 0, 0, 1, 1, 1, 32'h50, 0);
        add(0, 32'h00, 0, 0, 1, 0, 1, 32'h50, 1);
        add(0, 32'h00, 0, 0, 1, 0, 1, 32'h50, 1);
        add(1, 32'h54, 0, 0, 1, 1, 1, 32'h54, 0);
        add(0, 32'h00, 0, 0, 1, 0, 1, 32'h54, 1);
        add(1, 32'h58, 1, 0, 0, 1, 1, 32'h58, 0);

        // Reset held with random inputs
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            inst = $urandom;
            @(posedge clk);
            #1;
            check_outputs($sformatf("reset%0d", c), 1'b0, 1'b1, 32'h0, 32'h0, NOP_I);
        end

        // Release and take the first beat
        reset = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        inst = 32'h00500093;
        @(posedge clk);
        #1;
        check_outputs("first", 1'b1, 1'b1, 32'h100, 32'h104, 32'h00500093);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].st, vecs[i].fl, vecs[i].ordy);
            @(posedge clk);
            #1;
            check_outputs($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_pc,
                          vecs[i].e_pc + 32'd4,
                          vecs[i].e_nop ? NOP_I : inst_of(vecs[i].e_pc));
        end

        // Fill the skid behind 0x58 while stalled
        drive(1'b1, 32'h5C, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("full", 1'b1, 1'b0, 32'h58, 32'h5C, inst_of(32'h58));

        // Asynchronous reset between edges: outputs clear without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 1'b1, 32'h0, 32'h0, NOP_I);

        // Release; the old skid beat 0x5C must not resurface
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("post_rst", 1'b1, 1'b1, 32'h200, 32'h204, inst_of(32'h200));
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("post_rst_drain", 1'b0, 1'b1, 32'h200, 32'h204, NOP_I);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Parametrised IF/ID pipeline register for the pipelined RISC-V core, replacing the plain capture register between fetch and decode. It adds a valid/ready handshake, stall and flush control for the hazard unit, NOP injection on bubbles, and a one-entry skid buffer, so fetch can run at full rate while decode back-pressures. Payload is PC, PC+4 and the instruction word.

## Interface
- XLEN, 32, width of pc and pcAdd4 fields
- ILEN, 32, width of instruction field
- NOP, 32'h00000013 (addi x0,x0,0), instruction driven on instOut whenever no valid instruction is held
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously with clk
- inValid  in  1  fetch presents a valid pc/pcAdd4/inst
- inReady  out  1  stage can accept; equals NOT skidValid (registered)
- pc, pcAdd4  in  XLEN  fetch PC and PC+4
- inst  in  ILEN  fetched instruction
- stall  in  1  hazard-unit hold; effective downstream ready = outReady AND NOT stall
- flush  in  1  branch/jump taken; kills all held and incoming instructions this cycle
- outValid  out  1  pcOut/pcAdd4Out/instOut hold a live instruction
- outReady  in  1  decode accepts this cycle
- pcOut, pcAdd4Out  out  XLEN  registered PC fields
- instOut  out  ILEN  registered instruction, NOP when outValid=0

## Operation
- Storage: main slot (drives outputs, flag outValid) and skid slot (flag skidValid), each holding pc/pcAdd4/inst.
- inFire = inValid & inReady; outFire = outValid & outReady & ~stall.
- Priority 1, flush=1: outValid<=0, skidValid<=0, instOut<=NOP, pcOut/pcAdd4Out hold, incoming beat dropped even if inFire.
- Priority 2, main slot free (outValid=0 or outFire):
  - skidValid=1: main <= skid, outValid<=1, skidValid<=0; if inFire same cycle, skid <= input, skidValid<=1.
  - skidValid=0 and inFire: main <= input, outValid<=1.
  - otherwise: outValid<=0, instOut<=NOP, PC fields hold.
- Priority 3, main slot held (outValid=1, no outFire): if inFire, skid <= input, skidValid<=1.
- Ordering strictly FIFO; no beat duplicated or lost except by flush.
- Invariant: skidValid=1 implies outValid=1.

## Timing
- Reset (reset=0): outValid=0, skidValid=0, inReady=1, pcOut=0, pcAdd4Out=0, instOut=NOP, skid contents 0.
- Latency: beat accepted at edge N visible on outputs after edge N (1 cycle), when main slot free.
- Throughput: 1 beat/cycle with outReady=1, stall=0.
- Back-pressure: first held cycle still accepts one beat into skid; inReady drops the following cycle; no combinational path from outReady/stall to inReady.
- Release: after stall clears, skid drains to main in 1 cycle; inReady returns high the cycle after.
- Simultaneous flush+stall: flush wins. Simultaneous flush+inFire: beat dropped, inReady remains 1 after.
- Reset mid-operation: both slots cleared asynchronously, outputs to reset values regardless of clk.

## Test plan
- Reset: reset=0 with random inputs -> outValid=0, instOut=32'h00000013, pcOut=0, inReady=1; release, feed pc=0x100, inst=0x00500093 -> next cycle outValid=1, pcOut=0x100, pcAdd4Out=0x104, instOut=0x00500093.
- Streaming: 8 consecutive beats pc=0x0..0x1C, outReady=1 -> outputs appear in order, 1-cycle latency, no gaps.
- Stall/skid: stall=1 while pc=0x20 in main, pc=0x24 offered -> 0x24 into skid, inReady=0 next cycle, pcOut holds 0x20; stall=0 -> 0x20 consumed, then 0x24, then new beats, none lost.
- Flush: main=0x40, skid=0x44, inFire of 0x48 with flush=1 -> next cycle outValid=0, instOut=NOP, inReady=1; 0x40/0x44/0x48 never appear.
- Bubble: inValid=0 for 2 cycles after beat 0x50 consumed -> outValid=0, instOut=NOP, pcOut holds 0x50.
- Async reset mid-stall: reset=0 between edges with both slots full -> outputs to reset values immediately, before next clk edge.
